jacobi_convergence_monitor: RTL

- Sits directly downstream of the start-controlled FP adder/subtractor stage.
- Consumes the per-element difference x_new - x_old that the stage produces as a 32-bit IEEE-754 single.
- Per sweep of VECTOR_LEN elements, tracks the maximum |difference|, compares it against a programmable tolerance and counts Jacobi iterations.
- Reports convergence, timeout or an anomaly to the iteration controller.

---
 rtl/jacobi_convergence_monitor.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/jacobi_convergence_monitor.sv
`timescale 1ns/1ps
// jacobi_convergence_monitor
//
// Watches the per-element differences (x_new - x_old) coming out of the FP
// subtract stage. For every sweep of VECTOR_LEN elements it keeps the largest
// |difference|, then in a single DECIDE cycle compares that maximum against the
// tolerance. The iteration controller sees one of three outcomes: a sweep_done
// pulse (keep iterating), converged, or timeout after MAX_ITER sweeps.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | cleared, waiting for start
// COLLECT | accepting elements, tracking max |diff| and NaNs
// DECIDE  | one cycle: tolerance compare, iteration count, next step
// DONE    | converged or timed out, outputs frozen until start drops
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start                level enable; low clears everything synchronously
//   diff_in/diff_valid   IEEE-754 single difference and its qualifier
//   tolerance            IEEE-754 single threshold (sign ignored), read in DECIDE
//   max_abs_diff         max |diff| of the current/final sweep
//   sweep_done           one-cycle pulse after each non-final sweep
//   done/converged/timeout  final outcome levels
//   nan_seen             NaN seen in the current sweep
//   overrun              element arrived while in DECIDE or DONE (sticky)
//   iteration_count      completed sweeps
//   busy                 COLLECT or DECIDE
module jacobi_convergence_monitor #(
    parameter int VECTOR_LEN = 8,
    parameter int ITER_W     = 16,
    parameter int MAX_ITER   = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       diff_in,
    input  logic              diff_valid,
    input  logic [31:0]       tolerance,
    output logic [31:0]       max_abs_diff,
    output logic              sweep_done,
    output logic              done,
    output logic              converged,
    output logic              timeout,
    output logic              nan_seen,
    output logic              overrun,
    output logic [ITER_W-1:0] iteration_count,
    output logic              busy
);

    localparam int CNT_W = $clog2(VECTOR_LEN);
    localparam logic [CNT_W-1:0]  LAST_ELEM = CNT_W'(VECTOR_LEN - 1);
    localparam logic [ITER_W-1:0] ITER_LIM  = ITER_W'(MAX_ITER);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  elem_cnt;
    logic [30:0]       max_mag;

    logic [30:0]       diff_mag;
    logic              diff_is_nan;
    logic              conv_now;
    logic [ITER_W-1:0] iter_next;
    logic              unused_sign_bits;

    // Sign bits never matter: magnitudes only. Dropping bit 31 also folds -0 into +0.
    assign diff_mag         = diff_in[30:0];
    assign diff_is_nan      = (&diff_in[30:23]) && (|diff_in[22:0]);
    assign unused_sign_bits = diff_in[31] ^ tolerance[31];

    // For non-NaN positive IEEE values, the unsigned order of bits [30:0]
    // equals the numeric order, so no FP comparator is needed.
    assign conv_now  = !nan_seen && (max_mag <= tolerance[30:0]);
    assign iter_next = iteration_count + 1'b1;

    assign max_abs_diff = {1'b0, max_mag};
    assign busy         = (state == S_COLLECT) || (state == S_DECIDE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            elem_cnt        <= '0;
            max_mag         <= '0;
            sweep_done      <= 1'b0;
            done            <= 1'b0;
            converged       <= 1'b0;
            timeout         <= 1'b0;
            nan_seen        <= 1'b0;
            overrun         <= 1'b0;
            iteration_count <= '0;
        end else if (!start) begin
            state           <= S_IDLE;
            elem_cnt        <= '0;
            max_mag         <= '0;
            sweep_done      <= 1'b0;
            done            <= 1'b0;
            converged       <= 1'b0;
            timeout         <= 1'b0;
            nan_seen        <= 1'b0;
            overrun         <= 1'b0;
            iteration_count <= '0;
        end else begin
            sweep_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    state <= S_COLLECT;
                end

                S_COLLECT: begin
                    if (diff_valid) begin
                        if (diff_is_nan) begin
                            nan_seen <= 1'b1;
                        end else if (diff_mag > max_mag) begin
                            max_mag <= diff_mag;
                        end
                        if (elem_cnt == LAST_ELEM) begin
                            elem_cnt <= '0;
                            state    <= S_DECIDE;
                        end else begin
                            elem_cnt <= elem_cnt + 1'b1;
                        end
                    end
                end

                S_DECIDE: begin
                    iteration_count <= iter_next;
                    if (diff_valid) begin
                        overrun <= 1'b1;
                    end
                    if (conv_now) begin
                        converged <= 1'b1;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end else if (iter_next == ITER_LIM) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        sweep_done <= 1'b1;
                        max_mag    <= '0;
                        nan_seen   <= 1'b0;
                        state      <= S_COLLECT;
                    end
                end

                S_DONE: begin
                    if (diff_valid) begin
                        overrun <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
